jtcop_mcu_bridge: RTL and testbench
===================================

Name: jtcop_mcu_bridge

Overview:
- Handshake bridge between the 68000 main-CPU security-chip window and the i8751 MCU port pins.
- Sits directly downstream of the game top's MCU select/data nets and directly upstream of the i8751 core ports P0, P2 and INT1.
- Latches CPU commands and raises the MCU interrupt with request/acknowledge tracking.
- Multiplexes command bytes onto P0 and assembles the MCU's 16-bit reply for the CPU.

Parameters:
- SYNC, 1: number of flip-flop stages (0–2) applied to the p2_o strobes before decoding. The MCU runs on a clock enable, so a value of 1 is required for timing margin.

Ports:
- clk, input, 1: system clock, shared by the CPU and the MCU clock enable.
- rst_n, input, 1: asynchronous, active-low reset.
- mcu_cs, input, 1: CPU select of the MCU window (sec[0]); level while the bus cycle is active.
- cpu_rnw, input, 1: CPU read/not-write.
- cpu_dsn, input, 2: CPU data strobes {UDSn, LDSn}, active low.
- cpu_dout, input, 16: CPU write data.
- mcu_din, output, 16: command register contents (the CPU-to-MCU data).
- mcu_dout, output, 16: reply register returned to the CPU.
- rpl_rdy, output, 1: reply-valid flag, readable by the CPU as a status bit.
- p0_o, input, 8: MCU port 0 output.
- p2_o, input, 8: MCU port 2 output. Bit 3 = interrupt ack (active low); 4 = rdhi_n; 5 = rdlo_n; 6 = wrlo_n; 7 = wrhi_n.
- p0_i, output, 8: MCU port 0 input.
- int1n, output, 1: MCU INT1, active low.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, and all of them hold while rst_n is low:
  - mcu_din = 0, mcu_dout = 0, p0_i = 0
  - int1n = 1, rpl_rdy = 0
  - pending = 0, all edge/sync registers = idle (strobes high, cs low)
- Reset applied mid-handshake discards the in-flight request; no interrupt is issued after release.
- CPU write:
  - Detected on the rising edge of mcu_cs with cpu_rnw = 0, using a registered mcu_cs (cs_l).
  - In that cycle, mcu_din[15:8] loads cpu_dout[15:8] if cpu_dsn[1] = 0, and mcu_din[7:0] loads cpu_dout[7:0] if cpu_dsn[0] = 0. A lane with its strobe high keeps its old value.
  - The write also raises a request (req).
- CPU read:
  - Detected on the rising edge of mcu_cs with cpu_rnw = 1.
  - Clears rpl_rdy on the next clock. mcu_dout is unchanged.
- Interrupt FSM, three states:
  - IDLE (int1n = 1):
    - req → ASSERT, with int1n = 0 on the clock after the cs edge (1-cycle latency).
  - ASSERT (int1n = 0):
    - ack (synced p2_o[3] = 0) → ACKED, int1n = 1 the following clock.
    - req while in ASSERT is absorbed; int1n is already low.
  - ACKED (int1n = 1):
    - ack released (p2_o[3] = 1): go to ASSERT if pending, else to IDLE. Pending is cleared on that transition.
    - req while ack is still low sets pending. The pending request is never lost, and only one is queued; further writes overwrite mcu_din.
  - Ack and req in the same cycle: ack wins for int1n, and req sets pending.
- p0_i multiplexer, updated every clock from the synced strobes:
  - rdlo_n = 0 → mcu_din[7:0].
  - else rdhi_n = 0 → mcu_din[15:8].
  - else p0_i holds its value.
  - Both strobes low: the low byte wins.
- MCU writes are level-sensitive:
  - While wrhi_n = 0, mcu_dout[15:8] <= p0_o.
  - While wrlo_n = 0, mcu_dout[7:0] <= p0_o.
  - Both may be written in the same cycle.
- Reply completion:
  - The rising edge of synced wrlo_n sets rpl_rdy on the next clock.
  - A simultaneous CPU-read edge and wrlo_n rising edge leaves rpl_rdy = 1; set wins.
- Strobe timing: p2 strobes pass through SYNC register stages, so the effective latency from a pin to its effect is SYNC+1 clocks. p0_o is sampled in the same stage alignment as the strobes.
- No counters wrap. Every flag saturates at 1.

Test Plan:
- Reset check: drive rst_n = 0 mid-transfer with int1n low → int1n = 1, mcu_din = 0, rpl_rdy = 0 immediately (asynchronous). Release reset → no interrupt follows.
- Byte-masked write:
  - cs rises with rnw = 0, dsn = 2'b10, cpu_dout = 16'hA55A → mcu_din = 16'h005A, int1n = 0 one clock later.
  - Second write, dsn = 2'b01, cpu_dout = 16'h1234 → mcu_din = 16'h125A.
- MCU read-out: drive p2_o[5] = 0, then p2_o[4] = 0, then both low, with mcu_din = 16'hBEEF → p0_i = 8'hEF, then 8'hBE, then 8'hEF, each SYNC+1 clocks after the strobe.
- Ack and pending:
  - After int1n = 0, hold p2_o[3] = 0 → int1n = 1.
  - A CPU write during the ack sets pending.
  - Release ack → int1n = 0 again within 1 clock after the synced release; exactly one extra interrupt.
- Reply path:
  - p0_o = 8'h12 with wrhi_n pulsed low, then p0_o = 8'h34 with wrlo_n low, then wrlo_n released → mcu_dout = 16'h1234, rpl_rdy = 1.
  - A CPU read edge → rpl_rdy = 0.
- Collision: CPU read edge in the same cycle as the synced wrlo_n rising edge → rpl_rdy = 1.

Source files
------------

// File: rtl/jtcop_mcu_bridge.sv
// Purpose : bridge between the 68000 security-chip window and the i8751 MCU ports (P0, P2, INT1).
// Latency : CPU edge -> mcu_din/int1n 1 clk; MCU P2 strobe -> p0_i/mcu_dout/rpl_rdy/int1n SYNC+1 clks.
// Backpres: none; one request may be queued while INT1 is acknowledged, later writes overwrite mcu_din.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   mcu_cs, cpu_rnw      : CPU window select (level) and read/not-write
//   cpu_dsn, cpu_dout    : CPU data strobes {UDSn, LDSn} (active low) and write data
//   mcu_din              : command register (CPU -> MCU)
//   mcu_dout, rpl_rdy    : reply register (MCU -> CPU) and its valid flag
//   p0_o, p2_o           : MCU port outputs; p2_o[3]=ack_n [4]=rdhi_n [5]=rdlo_n [6]=wrlo_n [7]=wrhi_n
//   p0_i                 : MCU port 0 input (command byte read-out)
//   int1n                : MCU INT1, active low
module jtcop_mcu_bridge #(
    parameter int SYNC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mcu_cs,
    input  logic        cpu_rnw,
    input  logic [1:0]  cpu_dsn,
    input  logic [15:0] cpu_dout,
    output logic [15:0] mcu_din,
    output logic [15:0] mcu_dout,
    output logic        rpl_rdy,
    input  logic [7:0]  p0_o,
    input  logic [7:0]  p2_o,
    output logic [7:0]  p0_i,
    output logic        int1n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_ACKED
    } state_t;

    logic        r_cs_l;
    logic        w_cs_rise;
    logic        w_wr_req;
    logic        w_rd_req;
    logic [7:3]  w_p2;
    logic [7:0]  w_p0;
    logic        w_ack;
    logic        r_wrlo_l;
    logic        w_wrlo_rise;
    state_t      r_state;
    logic        r_pending;

    // P2 bits 2:0 carry nothing for this bridge.
    logic        w_unused_p2;
    assign w_unused_p2 = &{1'b0, p2_o[2:0]};

    // P0 data is delayed with the strobes so a write strobe always sees the
    // data byte that was on the pins in the same MCU cycle.
    generate
        if (SYNC == 0) begin : g_nosync
            assign w_p2 = p2_o[7:3];
            assign w_p0 = p0_o;
        end else begin : g_sync
            logic [7:3] r_p2_s [SYNC];
            logic [7:0] r_p0_s [SYNC];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC; i++) begin
                        r_p2_s[i] <= 5'h1f;
                        r_p0_s[i] <= 8'h00;
                    end
                end else begin
                    r_p2_s[0] <= p2_o[7:3];
                    r_p0_s[0] <= p0_o;
                    for (int i = 1; i < SYNC; i++) begin
                        r_p2_s[i] <= r_p2_s[i-1];
                        r_p0_s[i] <= r_p0_s[i-1];
                    end
                end
            end
            assign w_p2 = r_p2_s[SYNC-1];
            assign w_p0 = r_p0_s[SYNC-1];
        end
    endgenerate

    assign w_cs_rise   = mcu_cs & ~r_cs_l;
    assign w_wr_req    = w_cs_rise & ~cpu_rnw;
    assign w_rd_req    = w_cs_rise &  cpu_rnw;
    assign w_ack       = ~w_p2[3];
    assign w_wrlo_rise = w_p2[6] & ~r_wrlo_l;

    // Datapath: command latch, P0 read-out mux, reply assembly and reply flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_l   <= 1'b0;
            r_wrlo_l <= 1'b1;
            mcu_din  <= 16'h0000;
            mcu_dout <= 16'h0000;
            p0_i     <= 8'h00;
            rpl_rdy  <= 1'b0;
        end else begin
            r_cs_l   <= mcu_cs;
            r_wrlo_l <= w_p2[6];
            if (w_wr_req && !cpu_dsn[1]) mcu_din[15:8] <= cpu_dout[15:8];
            if (w_wr_req && !cpu_dsn[0]) mcu_din[7:0]  <= cpu_dout[7:0];
            // Low byte has priority when the MCU drives both read strobes.
            if (!w_p2[5])      p0_i <= mcu_din[7:0];
            else if (!w_p2[4]) p0_i <= mcu_din[15:8];
            if (!w_p2[7]) mcu_dout[15:8] <= w_p0;
            if (!w_p2[6]) mcu_dout[7:0]  <= w_p0;
            // Reply completion beats a colliding CPU read so no reply is lost.
            if (w_wrlo_rise)   rpl_rdy <= 1'b1;
            else if (w_rd_req) rpl_rdy <= 1'b0;
        end
    end

    // INT1 request/acknowledge tracking with a single-entry pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            int1n     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req) begin
                        r_state <= S_ASSERT;
                        int1n   <= 1'b0;
                    end
                end
                S_ASSERT: begin
                    if (w_ack) begin
                        r_state <= S_ACKED;
                        int1n   <= 1'b1;
                        if (w_wr_req) r_pending <= 1'b1;
                    end
                end
                S_ACKED: begin
                    if (!w_ack) begin
                        r_pending <= 1'b0;
                        if (r_pending || w_wr_req) begin
                            r_state <= S_ASSERT;
                            int1n   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_wr_req) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    int1n   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Purpose : self-checking bench for jtcop_mcu_bridge (SYNC = 1).
// Latency : strobe effects checked SYNC+1 clocks after the pin change, CPU effects 1 clock after the edge.
// Backpres: none; stimulus is fixed-length, a watchdog bounds the run.
module tb_jtcop_mcu_bridge;

    localparam int SYNC = 1;
    localparam int LAT  = SYNC + 1;

    logic        clk;
    logic        rst_n;
    logic        mcu_cs;
    logic        cpu_rnw;
    logic [1:0]  cpu_dsn;
    logic [15:0] cpu_dout;
    logic [15:0] mcu_din;
    logic [15:0] mcu_dout;
    logic        rpl_rdy;
    logic [7:0]  p0_o;
    logic [7:0]  p2_o;
    logic [7:0]  p0_i;
    logic        int1n;

    jtcop_mcu_bridge #(.SYNC(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mcu_cs   (mcu_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_dsn  (cpu_dsn),
        .cpu_dout (cpu_dout),
        .mcu_din  (mcu_din),
        .mcu_dout (mcu_dout),
        .rpl_rdy  (rpl_rdy),
        .p0_o     (p0_o),
        .p2_o     (p2_o),
        .p0_i     (p0_i),
        .int1n    (int1n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dsn;
        logic [15:0] dat;
        logic [15:0] exp_din;
    } wr_vec_t;

    typedef struct {
        logic [7:0] p2;
        logic [7:0] exp_p0i;
    } rd_vec_t;

    wr_vec_t     wr_tab [4];
    rd_vec_t     rd_tab [4];
    logic [15:0] sb_q [$];
    int          n_chk;
    int          n_err;
    int          n_fall;
    int          f0;

    always @(negedge int1n) n_fall++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_pop_chk(input string nm, input logic [15:0] act);
        logic [15:0] exp;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: got %h expected <none queued>", nm, act);
        end else begin
            exp = sb_q.pop_front();
            chk(nm, act, exp);
        end
    endtask

    task automatic cpu_start(input logic rnw, input logic [1:0] dsn, input logic [15:0] dat);
        mcu_cs   = 1'b1;
        cpu_rnw  = rnw;
        cpu_dsn  = dsn;
        cpu_dout = dat;
    endtask

    task automatic cpu_end();
        mcu_cs  = 1'b0;
        cpu_rnw = 1'b1;
        cpu_dsn = 2'b11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_err  = 0;
        n_fall = 0;

        // Command writes: byte masks applied from a cleared register.
        wr_tab[0] = '{dsn: 2'b10, dat: 16'hA55A, exp_din: 16'h005A};
        wr_tab[1] = '{dsn: 2'b01, dat: 16'h1234, exp_din: 16'h125A};
        wr_tab[2] = '{dsn: 2'b00, dat: 16'hBEEF, exp_din: 16'hBEEF};
        wr_tab[3] = '{dsn: 2'b11, dat: 16'h0000, exp_din: 16'hBEEF};
        // P0 read-out with mcu_din = BEEF: rdlo, rdhi, none (hold), both (low wins).
        rd_tab[0] = '{p2: 8'hDF, exp_p0i: 8'hEF};
        rd_tab[1] = '{p2: 8'hEF, exp_p0i: 8'hBE};
        rd_tab[2] = '{p2: 8'hFF, exp_p0i: 8'hBE};
        rd_tab[3] = '{p2: 8'hCF, exp_p0i: 8'hEF};

        rst_n = 1'b0;
        p0_o  = 8'h00;
        p2_o  = 8'hFF;
        cpu_dout = 16'h0000;
        cpu_end();
        repeat (3) tick();
        chk("rst_int1n",   {15'd0, int1n},   16'h0001);
        chk("rst_din",     mcu_din,          16'h0000);
        chk("rst_dout",    mcu_dout,         16'h0000);
        chk("rst_rpl_rdy", {15'd0, rpl_rdy}, 16'h0000);
        chk("rst_p0_i",    {8'd0, p0_i},     16'h0000);
        #3 rst_n = 1'b1;
        tick();
        chk("idle_int1n", {15'd0, int1n}, 16'h0001);

        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(wr_tab[i].exp_din);
            cpu_start(1'b0, wr_tab[i].dsn, wr_tab[i].dat);
            tick();
            sb_pop_chk("wr_din", mcu_din);
            chk("wr_int1n", {15'd0, int1n}, 16'h0000);
            cpu_end();
            tick();
        end

        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({8'h00, rd_tab[i].exp_p0i});
            p2_o = rd_tab[i].p2;
            tick();
            if (i == 0) chk("p0_i_early", {8'd0, p0_i}, 16'h0000);
            repeat (LAT - 1) tick();
            sb_pop_chk("p0_i", {8'd0, p0_i});
        end

        // Ack while asserted, a write during the ack queues exactly one more interrupt.
        p2_o = 8'hF7;
        tick();
        chk("ack_early_int1n", {15'd0, int1n}, 16'h0000);
        tick();
        chk("ack_int1n", {15'd0, int1n}, 16'h0001);
        cpu_start(1'b0, 2'b00, 16'h5555);
        tick();
        chk("pend_din",   mcu_din,          16'h5555);
        chk("pend_int1n", {15'd0, int1n},   16'h0001);
        cpu_end();
        tick();
        f0 = n_fall;
        p2_o = 8'hFF;
        tick();
        chk("rel_early_int1n", {15'd0, int1n}, 16'h0001);
        tick();
        chk("rel_int1n", {15'd0, int1n}, 16'h0000);
        p2_o = 8'hF7;
        repeat (LAT) tick();
        chk("ack2_int1n", {15'd0, int1n}, 16'h0001);
        p2_o = 8'hFF;
        repeat (6) tick();
        chk("idle2_int1n", {15'd0, int1n}, 16'h0001);
        chk("extra_irqs", 16'(n_fall - f0), 16'd1);

        // Reply assembly and completion flag.
        p2_o = 8'h7F; p0_o = 8'h12;
        repeat (LAT) tick();
        chk("rpl_hi", mcu_dout, 16'h1200);
        p2_o = 8'hBF; p0_o = 8'h34;
        repeat (LAT) tick();
        chk("rpl_lo",      mcu_dout,         16'h1234);
        chk("rpl_rdy_lo",  {15'd0, rpl_rdy}, 16'h0000);
        p2_o = 8'hFF;
        tick();
        chk("rpl_rdy_early", {15'd0, rpl_rdy}, 16'h0000);
        tick();
        chk("rpl_rdy_set", {15'd0, rpl_rdy}, 16'h0001);
        cpu_start(1'b1, 2'b00, 16'h0000);
        tick();
        chk("rd_clr_rdy",  {15'd0, rpl_rdy}, 16'h0000);
        chk("rd_dout",     mcu_dout,         16'h1234);
        cpu_end();
        tick();

        // CPU read edge coinciding with the synced wrlo_n rising edge.
        p2_o = 8'hBF; p0_o = 8'h56;
        repeat (LAT) tick();
        p2_o = 8'hFF;
        tick();
        cpu_start(1'b1, 2'b00, 16'h0000);
        tick();
        chk("coll_rpl_rdy", {15'd0, rpl_rdy}, 16'h0001);
        chk("coll_dout",    mcu_dout,         16'h1256);
        cpu_end();
        tick();

        // Asynchronous reset in the middle of a handshake.
        cpu_start(1'b0, 2'b00, 16'hCAFE);
        tick();
        cpu_end();
        p2_o = 8'hDF;
        tick();
        chk("pre_rst_int1n", {15'd0, int1n}, 16'h0000);
        f0 = n_fall;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_int1n",   {15'd0, int1n},   16'h0001);
        chk("arst_din",     mcu_din,          16'h0000);
        chk("arst_rpl_rdy", {15'd0, rpl_rdy}, 16'h0000);
        chk("arst_dout",    mcu_dout,         16'h0000);
        chk("arst_p0_i",    {8'd0, p0_i},     16'h0000);
        p2_o = 8'hFF;
        repeat (2) tick();
        chk("arst_hold_int1n", {15'd0, int1n}, 16'h0001);
        #3 rst_n = 1'b1;
        repeat (6) tick();
        chk("post_rst_int1n", {15'd0, int1n},       16'h0001);
        chk("post_rst_irqs",  16'(n_fall - f0),     16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
